// File: rtl/le_arb_pkg.sv
// Shared definitions for the compare arbiter: operand exception encodings
// and the default operand MSB index.
package le_arb_pkg;

  localparam int WIDTH_DEF = 14;

  // Top two operand bits carry the exception class, followed by the sign.
  typedef enum logic [1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_e;

endpackage

// File: rtl/le_cmp_arbiter_rr_grant.sv
// Round-robin one-hot grant: first set request at or above ptr, wrapping.
module rr_grant #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [TAG_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] gnt_dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_gnt;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign req_dbl = {req, req} >> ptr;
  assign rot     = req_dbl[N_REQ-1:0];
  assign rot_gnt = rot & (-rot);
  assign gnt_dbl = {rot_gnt, rot_gnt} << ptr;
  assign grant   = gnt_dbl[2*N_REQ-1 -: N_REQ];

endmodule

// File: rtl/le_cmp_arbiter.sv
// Shares one external pipelined A<=B comparator between N_REQ requesters;
// results return in acceptance order, tagged with the requester index.
module le_cmp_arbiter
  import le_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_REQ = 4,
  parameter int LAT   = 2,
  parameter int TAG_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*(WIDTH+1)-1:0] req_a,
  input  logic [N_REQ*(WIDTH+1)-1:0] req_b,
  output logic [WIDTH:0]             cmp_a,
  output logic [WIDTH:0]             cmp_b,
  output logic                       cmp_issue,
  input  logic                       cmp_le,
  output logic                       rsp_valid,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_le,
  output logic                       busy
);

  localparam int OP_W = WIDTH + 1;

  logic [TAG_W-1:0]          ptr_q;
  logic [N_REQ-1:0]          req_live;
  logic [N_REQ-1:0]          grant;
  logic                      hs;
  logic [TAG_W-1:0]          gnt_idx;
  logic [OP_W-1:0]           sel_a;
  logic [OP_W-1:0]           sel_b;
  logic [LAT:0]              pipe_vld;
  logic [LAT:0][TAG_W-1:0]   pipe_tag;

  // Masking requests during reset keeps req_ready low regardless of ptr.
  assign req_live = rst ? req_valid : '0;

  rr_grant #(
    .N_REQ (N_REQ),
    .TAG_W (TAG_W)
  ) u_rr_grant (
    .req   (req_live),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign req_ready = grant;
  assign hs        = |grant;

  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if ((grant & (N_REQ'(1) << i)) != '0) begin
        gnt_idx = TAG_W'(i);
        sel_a   = OP_W'(req_a >> (i * OP_W));
        sel_b   = OP_W'(req_b >> (i * OP_W));
      end
    end
  end

  // Stage 0 is the issue register; stage LAT lines up with a valid cmp_le.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q     <= '0;
      pipe_vld  <= '0;
      pipe_tag  <= '0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_tag   <= '0;
      rsp_le    <= 1'b0;
    end else begin
      if (hs) begin
        ptr_q <= (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
        cmp_a <= sel_a;
        cmp_b <= sel_b;
      end
      pipe_vld  <= {pipe_vld[LAT-1:0], hs};
      pipe_tag  <= {pipe_tag[LAT-1:0], gnt_idx};
      rsp_valid <= pipe_vld[LAT];
      if (pipe_vld[LAT]) begin
        rsp_tag <= pipe_tag[LAT];
        rsp_le  <= cmp_le;
      end
    end
  end

  assign cmp_issue = pipe_vld[0];
  assign busy      = (|pipe_vld) | rsp_valid;

endmodule

// File: tb/tb_le_cmp_arbiter.sv
// Self-checking bench for le_cmp_arbiter against a time-indexed history model.
module tb_le_cmp_arbiter;

  localparam int W    = 14;
  localparam int N    = 4;
  localparam int LAT  = 2;
  localparam int TW   = 2;
  localparam int OW   = W + 1;
  localparam int MAXC = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*OW-1:0] req_a = '0;
  logic [N*OW-1:0] req_b = '0;
  logic [OW-1:0]   cmp_a;
  logic [OW-1:0]   cmp_b;
  logic            cmp_issue;
  logic            cmp_le = 1'b0;
  logic            rsp_valid;
  logic [TW-1:0]   rsp_tag;
  logic            rsp_le;
  logic            busy;

  always #5 clk = ~clk;

  le_cmp_arbiter #(
    .WIDTH (W),
    .N_REQ (N),
    .LAT   (LAT),
    .TAG_W (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_issue (cmp_issue),
    .cmp_le    (cmp_le),
    .rsp_valid (rsp_valid),
    .rsp_tag   (rsp_tag),
    .rsp_le    (rsp_le),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int ptr_m = 0;
  int g_cur = -1;
  bit chk_en = 1'b0;

  // Per-cycle history: handshake, its tag/operands, and the cmp_le driven.
  bit            hs_hist  [MAXC];
  int            tag_hist [MAXC];
  logic [OW-1:0] a_hist   [MAXC];
  logic [OW-1:0] b_hist   [MAXC];
  bit            le_hist  [MAXC];

  logic          e_issue = 1'b0;
  logic          e_rv    = 1'b0;
  logic          e_le    = 1'b0;
  logic          e_busy  = 1'b0;
  logic [OW-1:0] e_a     = '0;
  logic [OW-1:0] e_b     = '0;
  int            e_tag   = 0;

  function automatic int model_grant(int p, logic [N-1:0] v, logic r);
    logic [N-1:0] t;
    if (!r) return -1;
    for (int off = 0; off < N; off++) begin
      t = v >> ((p + off) % N);
      if (t[0]) return (p + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    int k;
    g_cur = model_grant(ptr_m, req_valid, rst);
    if (cyc < MAXC) le_hist[cyc] = cmp_le;
    @(negedge clk);
    if (chk_en) begin
      chk("req_ready", 64'(req_ready), 64'(onehot(g_cur)));
      chk("cmp_issue", 64'(cmp_issue), 64'(e_issue));
      chk("cmp_a",     64'(cmp_a),     64'(e_a));
      chk("cmp_b",     64'(cmp_b),     64'(e_b));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("rsp_tag",   64'(rsp_tag),   64'(e_tag));
      chk("rsp_le",    64'(rsp_le),    64'(e_le));
      chk("busy",      64'(busy),      64'(e_busy));
    end
    @(posedge clk);
    #1;
    if (cyc >= MAXC) begin
      n_err++;
      $fatal(1, "FAIL cycle budget exceeded at %0d", cyc);
    end
    if (!rst) begin
      for (int j = 0; j <= cyc; j++) hs_hist[j] = 1'b0;
      ptr_m   = 0;
      e_issue = 1'b0;
      e_a     = '0;
      e_b     = '0;
      e_rv    = 1'b0;
      e_tag   = 0;
      e_le    = 1'b0;
      e_busy  = 1'b0;
    end else begin
      hs_hist[cyc] = (g_cur >= 0);
      if (g_cur >= 0) begin
        tag_hist[cyc] = g_cur;
        a_hist[cyc]   = OW'(req_a >> (g_cur * OW));
        b_hist[cyc]   = OW'(req_b >> (g_cur * OW));
        ptr_m         = (g_cur + 1) % N;
        e_a           = a_hist[cyc];
        e_b           = b_hist[cyc];
      end
      e_issue = hs_hist[cyc];
      // Response for a handshake at k appears at k+2+LAT, carrying cmp_le of k+1+LAT.
      k    = cyc - 1 - LAT;
      e_rv = 1'b0;
      if (k >= 0 && hs_hist[k]) begin
        e_rv  = 1'b1;
        e_tag = tag_hist[k];
        e_le  = le_hist[cyc];
      end
      e_busy = 1'b0;
      for (int j = (k < 0 ? 0 : k); j <= cyc; j++) if (hs_hist[j]) e_busy = 1'b1;
    end
    cyc++;
    chk_en = 1'b1;
  endtask

  // Requesters still waiting for a grant keep their operands stable.
  task automatic refresh_ops();
    logic [N-1:0]    keep;
    logic [N*OW-1:0] m;
    keep = req_valid & ~onehot(g_cur);
    for (int i = 0; i < N; i++) begin
      if ((keep & (N'(1) << i)) == '0) begin
        m     = (N*OW)'({OW{1'b1}}) << (i * OW);
        req_a = (req_a & ~m) | ((N*OW)'(OW'($urandom)) << (i * OW));
        req_b = (req_b & ~m) | ((N*OW)'(OW'($urandom)) << (i * OW));
      end
    end
  endtask

  task automatic apply(input logic [N-1:0] v, input logic le);
    refresh_ops();
    req_valid = v;
    cmp_le    = le;
    tick();
  endtask

  task automatic hold_until_granted(input logic [N-1:0] v);
    logic [N-1:0] pend;
    pend = v;
    for (int n = 0; n < 4 * N && pend != '0; n++) begin
      apply(pend, 1'($urandom));
      pend = pend & ~onehot(g_cur);
    end
  endtask

  task automatic random_phase(input int ncyc);
    logic [N-1:0] nv;
    for (int n = 0; n < ncyc; n++) begin
      nv = req_valid & ~onehot(g_cur);
      for (int i = 0; i < N; i++)
        if ((nv & (N'(1) << i)) == '0 && $urandom_range(0, 99) < 55) nv = nv | (N'(1) << i);
      apply(nv, 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b0;
    apply('0, 1'b0);
    apply('0, 1'b1);
    rst = 1'b1;
    apply('0, 1'b0);

    // Single request from requester 2, comparator reports A<=B.
    apply(4'b0100, 1'b1);
    repeat (6) apply('0, 1'b1);

    // All requesters continuously valid: strict rotation, back-to-back responses.
    repeat (12) apply(4'b1111, 1'($urandom));
    repeat (6) apply('0, 1'($urandom));

    // Move ptr to 2 then present 1010: requester 3 first, then 1.
    apply(4'b0010, 1'b0);
    hold_until_granted(4'b1010);
    apply(4'b1111, 1'b1);
    repeat (6) apply('0, 1'b0);

    // Reset with compares in flight; they must vanish.
    repeat (3) apply(4'b1111, 1'b1);
    rst = 1'b0;
    apply(4'b1111, 1'b1);
    rst = 1'b1;
    apply(4'b0110, 1'b1);
    repeat (6) apply('0, 1'b1);

    // Idle with a toggling comparator output.
    repeat (10) apply('0, 1'($urandom));

    random_phase(300);
    repeat (8) apply('0, 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/le_cmp_arbiter.md
LE_CMP_ARBITER -- requirements
Module: le_cmp_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 14: operand MSB index; operands are WIDTH+1 bits in the FP format with 2 exception bits, then sign.
REQ-002 SHALL have parameter N_REQ, default 4: number of requesters.
REQ-003 SHALL have parameter LAT, default 2: clocks from the cmp_issue cycle to the cycle where cmp_le is valid; LAT >= 1.
REQ-004 SHALL have parameter TAG_W, default 2: requester index width, equal to clog2(N_REQ).
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic samples on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port req_valid, input, N_REQ bits: bit i means requester i has a compare pending.
REQ-008 SHALL have port req_ready, output, N_REQ bits: one-hot or zero grant; a handshake occurs when valid and ready are both high.
REQ-009 SHALL have ports req_a and req_b, input, N_REQ*(WIDTH+1) bits each: slice i carries requester i's operands A and B.
REQ-010 SHALL have ports cmp_a and cmp_b, output, WIDTH+1 bits each: operands driven to the shared comparator.
REQ-011 SHALL have port cmp_issue, output, 1 bit: cmp_a and cmp_b carry a new compare this cycle.
REQ-012 SHALL have port cmp_le, input, 1 bit: comparator result (A<=B), valid LAT cycles after cmp_issue.
REQ-013 SHALL have port rsp_valid, output, 1 bit: single-cycle result pulse, with no backpressure.
REQ-014 SHALL have ports rsp_tag (TAG_W bits) and rsp_le (1 bit), outputs: the originating requester and its result.
REQ-015 SHALL have port busy, output, 1 bit: at least one accepted compare has not yet produced its rsp_valid.

Function
REQ-016 SHALL grant combinationally the first requester with req_valid high, searching from pointer ptr upward and wrapping modulo N_REQ; req_ready is zero when no requester is valid.
REQ-017 SHALL, after a handshake with requester i, set ptr to (i+1) mod N_REQ; with no handshake, ptr is unchanged.
REQ-018 SHALL accept at most one compare per cycle and sustain one per cycle.
REQ-019 SHALL, for a handshake in cycle T: drive cmp_issue=1 in T+1 with registered req_a/req_b slice i; sample cmp_le in T+1+LAT; assert rsp_valid in T+2+LAT with rsp_tag=i and rsp_le=sampled cmp_le.
REQ-020 SHALL carry tags and valid bits through a (LAT+1)-stage shift register; responses are delivered in acceptance order.
REQ-021 SHALL hold cmp_a, cmp_b, rsp_tag and rsp_le at their last values when nothing is issued or returned; cmp_issue and rsp_valid are then 0.
REQ-022 SHALL ignore cmp_le in any cycle whose pipeline stage carries no valid bit.
REQ-023 SHALL give a requester with req_valid high but not granted no response; the bench treats its operands as required to stay stable.
REQ-024 SHALL keep busy = OR of the issue register valid, all shift-register valids and the rsp register valid.

Reset
REQ-025 SHALL, while rst=0 at a clock edge, clear ptr, all pipeline valids, cmp_issue, rsp_valid and busy, and set cmp_a, cmp_b, rsp_tag and rsp_le to 0.
REQ-026 SHALL drive req_ready to 0 while rst=0.
REQ-027 SHALL drop compares in flight when reset occurs mid-operation; no rsp_valid is produced for them after rst returns to 1.

Structure
REQ-028 SHALL place the exception encodings (00 zero, 01 normal, 10 inf, 11 NaN) and the default WIDTH in shared package le_arb_pkg.
REQ-029 SHALL implement the grant logic as sub-module rr_grant (inputs req, ptr; output one-hot grant); the comparator stays external.

Verification (LAT=2, N_REQ=4)
REQ-030 Scenario: requester 2 valid in cycle 5, with cmp_le=1 driven in cycle 8 -> cmp_issue in 6, rsp_valid in 9, rsp_tag=2, rsp_le=1, busy high in cycles 6-9.
REQ-031 Scenario: all four requesters valid continuously after reset -> grants 0,1,2,3,0,...; rsp_valid continuous from the 4th cycle after the first grant; tags in the same order.
REQ-032 Scenario: ptr=2 with req_valid=4'b1010 -> requester 3 granted first, then 1; ptr ends at 2.
REQ-033 Scenario: rst=0 for one cycle while 3 compares are in flight -> no rsp_valid afterward, busy=0, next grant goes to the lowest valid index.
REQ-034 Scenario: req_valid=0 for 10 cycles -> cmp_issue=0, cmp_a and cmp_b unchanged, rsp_valid=0.
REQ-035 Scenario: cmp_le toggled randomly while the pipeline is empty -> no rsp_valid.
